pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a FETCH/EXEC handshake,
// branch/jump/register-jump next-PC selection, ILLOP/XADR traps and
// user-mode interrupt entry with exception return address capture.
//
// Optional feature macro: PC_IRQ_LATCH_EN
//   defined   : a rising edge of irq sets a pending flag that is held until
//               the interrupt is taken or reset.
//   undefined : pending is the irq level seen at EXEC completion; no flag.
//
// Ports
//   clk         in   clock, rising-edge active
//   reset       in   asynchronous active-low reset
//   pc_src[2:0] in   next-PC select (000 seq, 001 br, 010 jmp, 011 jr,
//                    100 ILLOP, 101 XADR, 110/111 ILLOP)
//   cond        in   branch-taken condition
//   con_ba      in   branch target
//   jt[25:0]    in   jump index
//   reg_target  in   register-jump target
//   irq         in   external interrupt request
//   stall       in   hold current instruction in EXEC
//   imem_req    out  fetch request (FETCH only)
//   imem_ack    in   fetch complete
//   pc          out  current program counter
//   pc_plus4    out  pc + 4 with kernel bit preserved
//   epc         out  exception return address
//   valid       out  instruction at pc is executing (EXEC only)
//   kernel      out  pc[W-1]
//   irq_taken   out  high during the EXEC-completion cycle that takes an irq
module pc_sequencer #(
  parameter int unsigned  W         = 32,
  parameter logic [W-1:0] RESET_VEC = W'(32'h8000_0000),
  parameter logic [W-1:0] ILLOP_VEC = W'(32'h8000_0004),
  parameter logic [W-1:0] XADR_VEC  = W'(32'h8000_0008)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   pc_src,
  input  logic         cond,
  input  logic [W-1:0] con_ba,
  input  logic [25:0]  jt,
  input  logic [W-1:0] reg_target,
  input  logic         irq,
  input  logic         stall,
  output logic         imem_req,
  input  logic         imem_ack,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus4,
  output logic [W-1:0] epc,
  output logic         valid,
  output logic         kernel,
  output logic         irq_taken
);

  localparam int unsigned LOW_W = W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         idle_done_q, idle_done_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] epc_q, epc_d;

  logic [W-1:0] pc_plus4_c;
  logic [W-1:0] seq_pc_c;
  logic [W-1:0] trap_vec_c;
  logic         trap_c;
  logic         exec_done_c;
  logic         pending_c;
  logic         take_irq_c;

  // Sequential address: kernel bit kept, low W-1 bits wrap.
  assign pc_plus4_c = {pc_q[W-1], pc_q[W-2:0] + LOW_W'(4)};

  // Non-trapping next PC; register jumps can only keep, never set, kernel.
  always_comb begin
    seq_pc_c = pc_plus4_c;
    case (pc_src)
      3'b001:  seq_pc_c = cond ? con_ba : pc_plus4_c;
      3'b010:  seq_pc_c = {pc_q[W-1], pc_plus4_c[W-2:28], jt, 2'b00};
      3'b011:  seq_pc_c = {reg_target[W-1] & pc_q[W-1], reg_target[W-2:0]};
      default: seq_pc_c = pc_plus4_c;
    endcase
  end

  // Codes 1xx trap; only 101 goes to XADR, reserved codes behave as ILLOP.
  assign trap_c      = pc_src[2];
  assign trap_vec_c  = (pc_src == 3'b101) ? XADR_VEC : ILLOP_VEC;
  assign exec_done_c = (state_q == ST_EXEC) && !stall;
  // Traps outrank interrupts; kernel mode masks interrupts.
  assign take_irq_c  = exec_done_c && !trap_c && pending_c && !pc_q[W-1];

`ifdef PC_IRQ_LATCH_EN
  logic irq_q, irq_d;
  logic pend_q, pend_d;
  logic irq_rise_c;

  // A rise in the completion cycle itself counts as pending.
  assign irq_rise_c = irq && !irq_q;
  assign pending_c  = pend_q || irq_rise_c;

  // Pending flag: set on irq rising edge, cleared when taken.
  always_comb begin
    irq_d  = irq;
    pend_d = pending_c && !take_irq_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
    end
  end
`else
  assign pending_c = irq;
`endif

  // State and architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idle_done_q <= 1'b0;
      pc_q        <= RESET_VEC;
      epc_q       <= '0;
    end else begin
      state_q     <= state_d;
      idle_done_q <= idle_done_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
    end
  end

  // Next-state, PC/EPC update and handshake outputs.
  // IDLE spends one full cycle after reset release so the first fetch
  // request appears after the second rising edge.
  always_comb begin
    state_d     = state_q;
    idle_done_d = idle_done_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    imem_req    = 1'b0;
    valid       = 1'b0;
    irq_taken   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle_done_d = 1'b1;
        if (idle_done_q) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        valid = 1'b1;
        if (exec_done_c) begin
          state_d = ST_FETCH;
          if (trap_c) begin
            pc_d  = trap_vec_c;
            epc_d = pc_plus4_c;
          end else if (take_irq_c) begin
            pc_d      = XADR_VEC;
            epc_d     = seq_pc_c;
            irq_taken = 1'b1;
          end else begin
            pc_d = seq_pc_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign pc_plus4 = pc_plus4_c;
  assign kernel   = pc_q[W-1];

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed instruction sequence with literal
// expectations plus a cycle-by-cycle behavioural reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h8000_0000;
  localparam logic [31:0] IV = 32'h8000_0004;
  localparam logic [31:0] XV = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  pc_src;
  logic        cond;
  logic [31:0] con_ba;
  logic [25:0] jt;
  logic [31:0] reg_target;
  logic        irq;
  logic        stall;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        valid;
  logic        kernel;
  logic        irq_taken;

  int checks;
  int failures;
  bit cmp_en;
  logic [31:0] last_exp;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .pc_src     (pc_src),
    .cond       (cond),
    .con_ba     (con_ba),
    .jt         (jt),
    .reg_target (reg_target),
    .irq        (irq),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .epc        (epc),
    .valid      (valid),
    .kernel     (kernel),
    .irq_taken  (irq_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase;      // 0 idle, 1 fetch, 2 exec
  int          m_idle_edges;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_pend;
  logic        m_irq_prev;

  function automatic logic [31:0] f_plus4(input logic [31:0] p);
    return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] f_seq(input logic [31:0] p);
    logic [31:0] jv;
    jv = {6'd0, jt} << 2;
    case (pc_src)
      3'd1:    return cond ? con_ba : f_plus4(p);
      3'd2:    return (p & 32'h8000_0000) | (f_plus4(p) & 32'h7000_0000) | jv;
      3'd3:    return (reg_target & 32'h7FFF_FFFF) | (reg_target & p & 32'h8000_0000);
      default: return f_plus4(p);
    endcase
  endfunction

  function automatic logic f_pending();
`ifdef PC_IRQ_LATCH_EN
    return m_pend | (irq & ~m_irq_prev);
`else
    return irq;
`endif
  endfunction

  function automatic logic f_taken();
    return (m_phase == 2) && !stall && (pc_src < 3'd4) && f_pending() && !m_pc[31];
  endfunction

  always @(posedge clk or negedge reset) begin
    logic tk;
    logic pn;
    if (!reset) begin
      m_phase      = 0;
      m_idle_edges = 0;
      m_pc         = RV;
      m_epc        = 32'd0;
      m_pend       = 1'b0;
      m_irq_prev   = 1'b0;
    end else begin
      tk = f_taken();
      pn = f_pending();
      if (m_phase == 0) begin
        if (m_idle_edges == 1) m_phase = 1;
        else m_idle_edges = m_idle_edges + 1;
      end else if (m_phase == 1) begin
        if (imem_ack) m_phase = 2;
      end else if (!stall) begin
        if (pc_src >= 3'd4) begin
          m_epc = f_plus4(m_pc);
          m_pc  = (pc_src == 3'd5) ? XV : IV;
        end else if (tk) begin
          m_epc = f_seq(m_pc);
          m_pc  = XV;
        end else begin
          m_pc = f_seq(m_pc);
        end
        m_phase = 1;
      end
      m_pend     = pn & ~tk;
      m_irq_prev = irq;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pc", pc, m_pc);
      chk("m_epc", epc, m_epc);
      chk("m_imem_req", imem_req, (m_phase == 1));
      chk("m_valid", valid, (m_phase == 2));
      chk("m_pc_plus4", pc_plus4, f_plus4(m_pc));
      chk("m_kernel", kernel, m_pc[31]);
      chk("m_irq_taken", irq_taken, f_taken());
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Precondition: just after an edge, DUT in FETCH.
  task automatic instr(input logic [2:0] src, input logic c, input logic [31:0] cba,
                       input logic [25:0] j, input logic [31:0] rt, input logic irqp,
                       input int stalls, input int ack_wait,
                       input logic [31:0] exp_pc, input logic exp_taken);
    imem_ack = 1'b0;
    repeat (ack_wait) step();
    imem_ack = 1'b1;
    step();
    imem_ack   = 1'b0;
    chk("exec_valid", valid, 1'b1);
    pc_src     = src;
    cond       = c;
    con_ba     = cba;
    jt         = j;
    reg_target = rt;
    irq        = irqp;
    stall      = (stalls > 0);
    for (int k = 0; k < stalls; k++) begin
      step();
      chk("stall_pc_hold", pc, last_exp);
      if (k == stalls - 1) stall = 1'b0;
    end
    #1;
    chk("irq_taken", irq_taken, exp_taken);
    step();
    irq    = 1'b0;
    pc_src = 3'd0;
    stall  = 1'b0;
    chk("next_pc", pc, exp_pc);
    last_exp = exp_pc;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cmp_en     = 1'b0;
    reset      = 1'b0;
    pc_src     = 3'd0;
    cond       = 1'b0;
    con_ba     = 32'd0;
    jt         = 26'd0;
    reg_target = 32'd0;
    irq        = 1'b0;
    stall      = 1'b0;
    imem_ack   = 1'b1;
    last_exp   = RV;
    repeat (2) step();
    cmp_en = 1'b1;
    chk("rst_pc", pc, RV);
    chk("rst_epc", epc, 32'd0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_irq_taken", irq_taken, 1'b0);

    reset = 1'b1;
    step();
    chk("idle_req", imem_req, 1'b0);
    step();
    chk("first_req", imem_req, 1'b1);

    // Sequential fetch from reset vector.
    instr(3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0004, 0);
    instr(3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0008, 0);
    // Drop to user mode, then branches taken / not taken.
    instr(3'd3, 0, 0, 0, 32'h0000_0100, 0, 0, 0, 32'h0000_0100, 0);
    chk("user_kernel", kernel, 1'b0);
    instr(3'd1, 1, 32'h40, 0, 0, 0, 0, 0, 32'h0000_0040, 0);
    instr(3'd3, 0, 0, 0, 32'h0000_0100, 0, 0, 0, 32'h0000_0100, 0);
    instr(3'd1, 0, 32'h40, 0, 0, 0, 0, 0, 32'h0000_0104, 0);
    // Jump to 0x200, then user interrupt.
    instr(3'd2, 0, 0, 26'h80, 0, 0, 0, 0, 32'h0000_0200, 0);
    instr(3'd0, 0, 0, 0, 0, 1, 0, 0, XV, 1);
    chk("irq_epc", epc, 32'h0000_0204);
    // Kernel-preserving jump, then kernel irq ignored on a jr to user.
    instr(3'd2, 0, 0, 26'h4, 0, 0, 0, 0, 32'h8000_0010, 0);
    chk("jmp_kernel", kernel, 1'b1);
    instr(3'd3, 0, 0, 0, 32'h0000_0300, 1, 0, 0, 32'h0000_0300, 0);
`ifdef PC_IRQ_LATCH_EN
    instr(3'd0, 0, 0, 0, 0, 0, 0, 0, XV, 1);
    chk("late_irq_epc", epc, 32'h0000_0304);
`else
    instr(3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0304, 0);
    chk("late_irq_epc", epc, 32'h0000_0204);
`endif
    // User jr cannot enter kernel.
    instr(3'd3, 0, 0, 0, 32'h0000_0200, 0, 0, 0, 32'h0000_0200, 0);
    instr(3'd3, 0, 0, 0, 32'h8000_0020, 0, 0, 0, 32'h0000_0020, 0);
    chk("jr_kernel", kernel, 1'b0);
    instr(3'd2, 0, 0, 26'h80, 0, 0, 0, 0, 32'h0000_0200, 0);
    // ILLOP outranks interrupt; XADR and reserved codes.
    instr(3'd4, 0, 0, 0, 0, 1, 0, 0, IV, 0);
    chk("illop_epc", epc, 32'h0000_0204);
    instr(3'd5, 0, 0, 0, 0, 0, 0, 0, XV, 0);
    chk("xadr_epc", epc, 32'h8000_0008);
    instr(3'd6, 0, 0, 0, 0, 0, 0, 0, IV, 0);
    chk("rsvd_epc", epc, 32'h8000_000C);
    // Three stall cycles, then reset mid-fetch.
    instr(3'd0, 0, 0, 0, 0, 0, 3, 0, 32'h8000_0008, 0);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_pc", pc, RV);
    chk("async_rst_req", imem_req, 1'b0);
    chk("async_rst_epc", epc, 32'd0);
    step();
    reset = 1'b1;
    last_exp = RV;
    step();
    chk("idle_req2", imem_req, 1'b0);
    step();
    // Delayed ack, then PC wrap in kernel and user space.
    instr(3'd0, 0, 0, 0, 0, 0, 0, 2, 32'h8000_0004, 0);
    instr(3'd3, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0);
    chk("wrap_k_p4", pc_plus4, 32'h8000_0000);
    instr(3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 0);
    instr(3'd3, 0, 0, 0, 32'h7FFF_FFFC, 0, 0, 0, 32'h7FFF_FFFC, 0);
    chk("wrap_u_p4", pc_plus4, 32'h0000_0000);
    instr(3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0);

    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
